// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: operation encodings
// and the op-select width.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic valid/ready register slice. The valid path is registered; ready is
// combinational from the downstream side so a full slice can stream each cycle.
module logic_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its data stable until then.
  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  always_comb begin
    load   = !v_q || out_ready;
    v_d    = v_q;
    data_d = data_q;
    if (load) begin
      v_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = load;
  assign out_valid = v_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit logic unit with valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to add registered zero/parity result flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             out_zero,
  output logic             out_parity,
`endif
  output logic [WIDTH-1:0] out_data
);

  localparam int S1_W = OP_W + 2 * WIDTH;
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int S2_W = WIDTH + 2;
`else
  localparam int S2_W = WIDTH;
`endif

  logic             s1_in_ready;
  logic [S1_W-1:0]  s1_data;
  logic             v1;
  logic             s2_in_ready;
  logic [S2_W-1:0]  s2_in_data;
  logic [S2_W-1:0]  s2_data;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  op_e              s1_op;

  logic_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   ({in_op, in_a, in_b}),
    .out_valid (v1),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign s1_op = op_e'(s1_data[S1_W-1 -: OP_W]);
  assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
  assign s1_b  = s1_data[WIDTH-1:0];

  always_comb begin
    res = '0;
    case (s1_op)
      OP_NOT:  res = ~s1_a;
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_NAND: res = ~(s1_a & s1_b);
      OP_NOR:  res = ~(s1_a | s1_b);
      OP_XNOR: res = ~(s1_a ^ s1_b);
      OP_PASS: res = s1_a;
      default: res = s1_a;
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flags ride in the same register as the result so they hold with it.
  assign s2_in_data = {~|res, ^res, res};
`else
  assign s2_in_data = res;
`endif

  logic_pipe_stage #(.WIDTH(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign out_data = s2_data[WIDTH-1:0];
`ifdef LOGIC_UNIT_FLAGS_EN
  assign out_zero   = s2_data[WIDTH+1];
  assign out_parity = s2_data[WIDTH];
`endif

  assign in_ready = s1_in_ready & rst_n;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at widths 4, 1, 64 and 8; flag checks
// are active when LOGIC_UNIT_FLAGS_EN is defined.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=4 instance
  logic       v4, rdy4, ov4, ordy4;
  logic [2:0] op4;
  logic [3:0] a4, b4, od4;
  // WIDTH=1, 64, 8 instances
  logic        v1i, rdy1, ov1;
  logic [0:0]  a1, b1, od1;
  logic        v64, rdy64, ov64;
  logic [63:0] a64, b64, od64;
  logic        v8, rdy8, ov8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, od8;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic z4, p4, z1, p1, z64, p64, z8, p8;
`endif

  logic_unit_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_op(op4),
    .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(ordy4),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(z4), .out_parity(p4),
`endif
    .out_data(od4));

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1i), .in_ready(rdy1), .in_op(OP_NOT),
    .in_a(a1), .in_b(b1), .out_valid(ov1), .out_ready(1'b1),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(z1), .out_parity(p1),
`endif
    .out_data(od1));

  logic_unit_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_op(OP_NOT),
    .in_a(a64), .in_b(b64), .out_valid(ov64), .out_ready(1'b1),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(z64), .out_parity(p64),
`endif
    .out_data(od64));

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_op(op8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(1'b1),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero(z8), .out_parity(p8),
`endif
    .out_data(od8));

  logic [2:0] op_v[8];
  logic [3:0] a_v[8], b_v[8], e_v[8];
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Streams n vectors into dut4 with out_ready=1, checking 2-cycle latency.
  task automatic run_stream(input int n);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) begin
        v4 = 1'b1; op4 = op_v[i]; a4 = a_v[i]; b4 = b_v[i];
      end else begin
        v4 = 1'b0;
      end
      @(negedge clk);
      if (i < n) check("stream_in_ready", 64'(rdy4), 64'd1);
      if (i >= 2 && i < n + 2) begin
        check("stream_valid", 64'(ov4), 64'd1);
        check("stream_data", 64'(od4), 64'(e_v[i-2]));
      end else begin
        check("stream_idle", 64'(ov4), 64'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    v4 = 0; op4 = 0; a4 = 0; b4 = 0; ordy4 = 1'b1;
    v1i = 0; a1 = 0; b1 = 0; v64 = 0; a64 = 0; b64 = 0;
    v8 = 0; op8 = 0; a8 = 0; b8 = 0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(ov4), 64'd0);
    check("rst_out_data", 64'(od4), 64'd0);
    check("rst_in_ready", 64'(rdy4), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rel_in_ready", 64'(rdy4), 64'd1);
    @(posedge clk); #1;

    // Back-to-back NOT
    op_v[0] = OP_NOT; a_v[0] = 4'b1000; b_v[0] = 4'b0000; e_v[0] = 4'b0111;
    op_v[1] = OP_NOT; a_v[1] = 4'b1101; b_v[1] = 4'b1111; e_v[1] = 4'b0010;
    op_v[2] = OP_NOT; a_v[2] = 4'b0101; b_v[2] = 4'b0011; e_v[2] = 4'b1010;
    run_stream(3);

    // All ops, A=1100 B=1010
    for (int i = 0; i < 8; i++) begin
      op_v[i] = 3'(i); a_v[i] = 4'b1100; b_v[i] = 4'b1010;
    end
    e_v[0] = 4'b0011; e_v[1] = 4'b1000; e_v[2] = 4'b1110; e_v[3] = 4'b0110;
    e_v[4] = 4'b0111; e_v[5] = 4'b0001; e_v[6] = 4'b1001; e_v[7] = 4'b1100;
    run_stream(8);

    // Back-pressure: feed 3 sets with out_ready=0
    ordy4 = 1'b0; op4 = OP_XOR; b4 = 4'b0110;
    v4 = 1'b1; a4 = 4'b0001;
    @(negedge clk); check("bp_ready0", 64'(rdy4), 64'd1);
    @(posedge clk); #1 a4 = 4'b0010;
    @(negedge clk); check("bp_ready1", 64'(rdy4), 64'd1);
    check("bp_valid1", 64'(ov4), 64'd0);
    @(posedge clk); #1 a4 = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_full", 64'(rdy4), 64'd0);
      check("bp_hold_valid", 64'(ov4), 64'd1);
      check("bp_hold_data", 64'(od4), 64'b0111);
      @(posedge clk); #1;
    end
    ordy4 = 1'b1;
    #1 check("bp_ready_comb", 64'(rdy4), 64'd1);
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
    for (int c = 0; c < 8; c++) begin
      logic took;
      @(negedge clk);
      took = v4 && rdy4;
      if (ov4 && ordy4) begin
        if (exp_q.size() == 0) check("bp_extra", 64'(od4), 64'hdead);
        else check("bp_drain", 64'(od4), 64'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      if (took) v4 = 1'b0;
    end
    check("bp_all_out", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight
    ordy4 = 1'b0; op4 = OP_NOT;
    v4 = 1'b1; a4 = 4'b0001;
    @(posedge clk); #1 a4 = 4'b0010;
    @(posedge clk); #1 v4 = 1'b0;
    @(negedge clk); check("rst_pre_valid", 64'(ov4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov4), 64'd0);
    check("async_rst_data", 64'(od4), 64'd0);
    check("async_rst_ready", 64'(rdy4), 64'd0);
    @(negedge clk); rst_n = 1'b1; ordy4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("no_stale", 64'(ov4), 64'd0);
    end
    @(posedge clk); #1;

    // Width extremes and 8-bit XOR
    v1i = 1'b1; a1 = 1'b1;
    v64 = 1'b1; a64 = '1;
    v8 = 1'b1; op8 = OP_XOR; a8 = 8'hF0; b8 = 8'h0F;
    @(posedge clk); #1 v1i = 1'b0; v64 = 1'b0; v8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("w1_valid", 64'(ov1), 64'd1);
    check("w1_data", 64'(od1), 64'd0);
    check("w64_valid", 64'(ov64), 64'd1);
    check("w64_data", od64, 64'd0);
    check("w8_xor_data", 64'(od8), 64'hFF);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("w1_zero", 64'(z1), 64'd1);
    check("w1_parity", 64'(p1), 64'd0);
    check("w64_zero", 64'(z64), 64'd1);
    check("w64_parity", 64'(p64), 64'd0);
    check("w8_xor_zero", 64'(z8), 64'd0);
    check("w8_xor_parity", 64'(p8), 64'd0);
`endif
    @(posedge clk); #1;
    v8 = 1'b1; op8 = OP_AND;
    @(posedge clk); #1 v8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("w8_and_valid", 64'(ov8), 64'd1);
    check("w8_and_data", 64'(od8), 64'h00);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("w8_and_zero", 64'(z8), 64'd1);
    check("w8_and_parity", 64'(p8), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
